// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback control FSM for the 8-bit quasi CPU.
// Optional feature macro: SEQ_TIMEOUT_EN (bounded FETCH wait with sticky fetch-error flag).
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_start, i_stop                 run control (start level, stop pulse)
//   o_imem_req, o_imem_addr         instruction fetch request and address (= pc)
//   i_imem_ack, i_imem_data         fetch acknowledge and instruction word
//   o_ir, o_op_code, o_src_addr1,
//   o_src_addr2, o_dest_addr        instruction register and its decode fields
//   o_rf_re, o_alu_en, o_rf_we      phase enables for DECODE / EXECUTE / WRITEBACK
//   o_pc, o_retired                 program counter, saturating retired-instruction count
//   o_busy, o_halted, o_fetch_err   status flags
module cpu_sequencer #(
   parameter int PC_W    = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_stop,
   output logic             o_imem_req,
   output logic [PC_W-1:0]  o_imem_addr,
   input  logic             i_imem_ack,
   input  logic [7:0]       i_imem_data,
   output logic [7:0]       o_ir,
   output logic [1:0]       o_op_code,
   output logic [1:0]       o_src_addr1,
   output logic [1:0]       o_src_addr2,
   output logic [1:0]       o_dest_addr,
   output logic             o_rf_re,
   output logic             o_alu_en,
   output logic             o_rf_we,
   output logic [PC_W-1:0]  o_pc,
   output logic [CNT_W-1:0] o_retired,
   output logic             o_busy,
   output logic             o_halted,
   output logic             o_fetch_err
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED} state_t;
   state_t            r_state, w_next;
   logic [PC_W-1:0]   r_pc;
   logic [7:0]        r_ir;
   logic [CNT_W-1:0]  r_retired;
   logic              r_stop, r_imem_req, r_rf_re, r_alu_en, r_rf_we, r_busy, r_halted;
   logic              w_stop;
`ifdef SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]     r_wait;
   logic              r_fetch_err, w_timeout;
   assign o_fetch_err = r_fetch_err;
`else
   logic              w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
   assign o_fetch_err = 1'b0;
`endif
   // a stop arriving in the WRITEBACK cycle itself still ends at this boundary
   assign w_stop = r_stop | i_stop;
   always_comb begin
      w_next = r_state;
`ifdef SEQ_TIMEOUT_EN
      w_timeout = 1'b0;
`endif
      case (r_state)
         IDLE, HALTED: w_next = (i_start && !i_stop) ? FETCH : r_state;
         FETCH: begin
            if (i_imem_ack)
               w_next = (i_imem_data == 8'hFF) ? HALTED : DECODE;
`ifdef SEQ_TIMEOUT_EN
            else if (r_wait == TW'(TIMEOUT - 1)) begin
               w_next    = HALTED;
               w_timeout = 1'b1;
            end
`endif
         end
         DECODE:    w_next = EXECUTE;
         EXECUTE:   w_next = WRITEBACK;
         WRITEBACK: w_next = w_stop ? IDLE : FETCH;
         default:   w_next = IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with r_state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_pc       <= '0;
         r_ir       <= '0;
         r_retired  <= '0;
         r_stop     <= 1'b0;
         r_imem_req <= 1'b0;
         r_rf_re    <= 1'b0;
         r_alu_en   <= 1'b0;
         r_rf_we    <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         r_wait      <= '0;
         r_fetch_err <= 1'b0;
`endif
      end else begin
         r_state    <= w_next;
         r_imem_req <= (w_next == FETCH);
         r_rf_re    <= (w_next == DECODE);
         r_alu_en   <= (w_next == EXECUTE);
         r_rf_we    <= (w_next == WRITEBACK);
         r_busy     <= (w_next == FETCH) || (w_next == DECODE) || (w_next == EXECUTE) || (w_next == WRITEBACK);
         r_halted   <= (w_next == HALTED);
         if (r_state == FETCH && i_imem_ack) begin
            r_ir <= i_imem_data;
            r_pc <= r_pc + PC_W'(1);
         end
         if (r_state == WRITEBACK && !(&r_retired))
            r_retired <= r_retired + CNT_W'(1);
         if (r_state == WRITEBACK && w_stop)
            r_stop <= 1'b0;
         else if (r_busy && i_stop)
            r_stop <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
         // zero outside FETCH, so every FETCH entry starts counting from 0
         r_wait <= (r_state == FETCH) ? r_wait + TW'(1) : '0;
         if (w_timeout)
            r_fetch_err <= 1'b1;
`endif
      end
   end
   assign o_imem_req  = r_imem_req;
   assign o_imem_addr = r_pc;
   assign o_pc        = r_pc;
   assign o_ir        = r_ir;
   assign o_op_code   = r_ir[7:6];
   assign o_src_addr1 = r_ir[5:4];
   assign o_src_addr2 = r_ir[3:2];
   assign o_dest_addr = r_ir[1:0];
   assign o_rf_re     = r_rf_re;
   assign o_alu_en    = r_alu_en;
   assign o_rf_we     = r_rf_we;
   assign o_retired   = r_retired;
   assign o_busy      = r_busy;
   assign o_halted    = r_halted;
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM that sequences the fetch, decode, execute and writeback phases of the 8-bit quasi CPU. It owns the program counter, issues a request/acknowledge fetch to instruction memory, and latches the instruction register. It pulses the phase enables (`rf_re`, `alu_en`, `rf_we`) that drive the register file and ALU. It sits between instruction memory and the decode/execute datapath, replacing free-running fetch with start/stop/halt control and a retired-instruction counter.

## Interface
- `PC_W`, 8: program counter / instruction address width.
- `CNT_W`, 16: retired-instruction counter width.
- `TIMEOUT`, 15: maximum consecutive FETCH wait cycles; used only with `SEQ_TIMEOUT_EN`.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; begins or resumes execution from IDLE or HALTED.
- `stop`  in  1  single-cycle pulse; requests a stop at the next instruction boundary.
- `imem_req`  out  1  fetch request; held high throughout FETCH.
- `imem_addr`  out  PC_W  fetch address; equals `pc`.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_data`  in  8  instruction word.
- `ir`  out  8  instruction register.
- `op_code`  out  2  `ir[7:6]`.
- `src_addr1`  out  2  `ir[5:4]`.
- `src_addr2`  out  2  `ir[3:2]`.
- `dest_addr`  out  2  `ir[1:0]`.
- `rf_re`  out  1  register-file read enable (DECODE).
- `alu_en`  out  1  ALU enable (EXECUTE).
- `rf_we`  out  1  register-file write enable (WRITEBACK).
- `pc`  out  PC_W  program counter.
- `retired`  out  CNT_W  count of completed instructions; saturates at all-ones.
- `busy`  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
- `halted`  out  1  high in HALTED.
- `fetch_err`  out  1  sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED. Encoding is free.
- IDLE: `start`=1 and `stop`=0 → FETCH. If both are high in the same cycle, `stop` wins and the state stays IDLE.
- FETCH: `imem_req`=1. When `imem_ack`=1:
  - `ir` ← `imem_data`.
  - `pc` ← `pc`+1, modulo 2^PC_W; `pc` wraps from all-ones to 0.
  - Next state is HALTED if `imem_data`==8'hFF, otherwise DECODE.
- DECODE: `rf_re`=1 for one cycle → EXECUTE.
- EXECUTE: `alu_en`=1 for one cycle → WRITEBACK.
- WRITEBACK: `rf_we`=1 for one cycle; `retired`+1 (saturating).
  - If the stop latch is set → IDLE, and the latch clears.
  - Otherwise → FETCH.
- Stop latch:
  - Set by `stop`=1 in any busy state.
  - Cleared on leaving WRITEBACK to IDLE, and on reset.
  - Ignored in IDLE and HALTED.
- HALT (8'hFF) does not increment `retired`. The rf/alu enables never pulse for it.
- HALTED: `halted`=1. `start`=1 and `stop`=0 → FETCH, resuming at the current `pc` (the word after the HALT). `fetch_err` is not cleared.
- The phase enables are mutually exclusive and each is high only in its own state.

## Timing
- Reset values: state IDLE; `pc`=0; `ir`=0, so all decode fields are 0; `retired`=0; `fetch_err`=0. All enables, `imem_req`, `busy` and `halted` are 0.
- Reset mid-operation: the next edge returns every output to its reset value. An in-flight fetch is abandoned, and `imem_req` is low from that cycle on.
- All outputs are registered or decoded from state/registers only, with no combinational path from inputs.
- Instruction latency:
  - FETCH with same-cycle ack: FETCH(1), DECODE(1), EXECUTE(1), WRITEBACK(1) = 4 cycles per instruction.
  - Each FETCH wait cycle without ack adds 1 cycle.
- `start` seen at edge N puts `imem_req` high after edge N.
- `ir` updates on the ack edge and is stable from DECODE through WRITEBACK.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH and increments on each FETCH cycle with `imem_ack`=0.
  - When it reaches `TIMEOUT` with no ack, the next state is HALTED and `fetch_err` ← 1.
  - `pc` is unchanged and `ir` is not loaded.
  - An ack arriving on the TIMEOUT-th cycle is accepted normally.
- `SEQ_TIMEOUT_EN` undefined: FETCH waits indefinitely, `fetch_err` is tied to 0, and the wait counter is not built.

## Test plan
- Reset, then `start`; memory acks every request with 8'h1B → `op_code`=0, `src_addr1`=1, `src_addr2`=2, `dest_addr`=3. `rf_we` pulses every 4 cycles, and `retired`=3 after 12 cycles from FETCH entry.
- Memory delays ack by 2 cycles each fetch → 6 cycles per instruction, and `imem_addr` holds steady while waiting.
- Program 8'h00, 8'h40, 8'hFF → `retired`=2, `halted`=1, `pc`=3. `start` then fetches from address 3.
- `stop` pulsed during EXECUTE → WRITEBACK completes, the state goes to IDLE, and `busy`=0. `start` and `stop` in the same cycle in IDLE → stays IDLE.
- `pc` preloaded by running to 8'hFF with non-halt instructions → the next fetch is from address 0. Reset asserted during DECODE → all outputs return to reset values on the next edge.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT`=15, `imem_ack` held 0 → after 15 cycles `halted`=1, `fetch_err`=1, `pc` unchanged. Without the macro, the FETCH state is still held after 100 cycles.
